// File: rtl/stream_mux_sv.sv
// N-channel registered stream multiplexer: manual-select or round-robin arbitration feeding a
// 1-entry output register. Optional packet locking is enabled with macro MUX_PKT_LOCK_EN.
module stream_mux_sv #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               out_last,
  output logic [SELW-1:0]    out_src,
  input  logic               out_ready
);

  localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

  logic [SELW-1:0]  ptr_r;
  logic             load_s;
  logic             xfer_s;
  logic             man_vld_s;
  logic             rr_vld_s;
  logic [SELW-1:0]  rr_idx_s;
  logic [SELW-1:0]  rr_cand_s;
  logic             gnt_vld_s;
  logic [SELW-1:0]  gnt_idx_s;
  logic [N-1:0]     grant_s;
  logic [WIDTH-1:0] sel_data_s;

  // Manual-select request: an out-of-range sel simply grants nothing.
  always_comb begin
    man_vld_s = 1'b0;
    if (int'(sel) < N) begin
      man_vld_s = in_valid[sel];
    end else begin
      man_vld_s = 1'b0;
    end
  end

  // Round-robin search from ptr_r; scanning downward lets the closest candidate win last.
  always_comb begin
    rr_vld_s  = 1'b0;
    rr_idx_s  = '0;
    rr_cand_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      rr_cand_s = SELW'((int'(ptr_r) + k) % N);
      if (in_valid[rr_cand_s]) begin
        rr_vld_s = 1'b1;
        rr_idx_s = rr_cand_s;
      end else begin
        rr_vld_s = rr_vld_s;
        rr_idx_s = rr_idx_s;
      end
    end
  end

`ifdef MUX_PKT_LOCK_EN
  typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t     state_r;
  lock_state_t     state_nxt_s;
  logic [SELW-1:0] lock_ch_r;
  logic [SELW-1:0] lock_ch_nxt_s;

  // Grant selection; an open packet pins the grant to its channel regardless of mode/sel.
  always_comb begin
    gnt_vld_s = mode ? rr_vld_s : man_vld_s;
    gnt_idx_s = mode ? rr_idx_s : sel;
    if (state_r == LOCKED) begin
      gnt_vld_s = in_valid[lock_ch_r];
      gnt_idx_s = lock_ch_r;
    end else begin
      gnt_vld_s = gnt_vld_s;
      gnt_idx_s = gnt_idx_s;
    end
  end

  // Packet lock next state: open on a non-last beat, close on the last beat of the locked channel.
  always_comb begin
    state_nxt_s   = state_r;
    lock_ch_nxt_s = lock_ch_r;
    case (state_r)
      FREE: begin
        if (xfer_s && !in_last[gnt_idx_s]) begin
          state_nxt_s   = LOCKED;
          lock_ch_nxt_s = gnt_idx_s;
        end else begin
          state_nxt_s   = FREE;
        end
      end
      LOCKED: begin
        if (xfer_s && in_last[gnt_idx_s]) begin
          state_nxt_s = FREE;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: begin
        state_nxt_s   = FREE;
        lock_ch_nxt_s = '0;
      end
    endcase
  end

  // Packet lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= FREE;
      lock_ch_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      lock_ch_r <= lock_ch_nxt_s;
    end
  end
`else
  // Grant selection; every beat is arbitrated on its own.
  always_comb begin
    gnt_vld_s = mode ? rr_vld_s : man_vld_s;
    gnt_idx_s = mode ? rr_idx_s : sel;
  end
`endif

  assign load_s = !out_valid || out_ready;
  assign xfer_s = gnt_vld_s && load_s && rst_n;

  // One-hot ready and data steering for the granted channel.
  always_comb begin
    grant_s    = '0;
    sel_data_s = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx_s == SELW'(i)) begin
        grant_s[i] = xfer_s;
        sel_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  assign in_ready = grant_s;

  // Output register: refills whenever empty or draining, otherwise holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (load_s) begin
      out_valid <= xfer_s;
      if (xfer_s) begin
        out_data <= sel_data_s;
        out_last <= in_last[gnt_idx_s];
        out_src  <= gnt_idx_s;
      end
    end
  end

  // Round-robin pointer moves past the winner only when arbitrating in round-robin mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (xfer_s && mode) begin
      ptr_r <= (gnt_idx_s == LAST_IDX) ? '0 : gnt_idx_s + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_mux_sv.sv
// Self-checking bench for stream_mux_sv (N=4, WIDTH=8): directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_stream_mux_sv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_src;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_last;
  int       m_src;
  int       m_ptr;
  bit       m_locked;
  int       m_lock_ch;

  stream_mux_sv #(.N(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = 8'h00; m_last = 1'b0; m_src = 0;
    m_ptr = 0; m_locked = 1'b0; m_lock_ch = 0;
  endtask

  // channel that the spec's rules accept this cycle, or -1
  function automatic int pick();
    if (!rst_n) return -1;
    if (m_valid && !out_ready) return -1;
`ifdef MUX_PKT_LOCK_EN
    if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
`endif
    if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < 4; k++) begin
      int c = (m_ptr + k) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    if (!m_valid || out_ready) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*8 +: 8];
        m_last  = in_last[g];
        m_src   = g;
        if (mode) m_ptr = (g + 1) % 4;
`ifdef MUX_PKT_LOCK_EN
        if (!m_locked && !in_last[g]) begin
          m_locked = 1'b1; m_lock_ch = g;
        end else if (m_locked && in_last[g]) begin
          m_locked = 1'b0;
        end
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // inputs are set while clk is low; check ready, clock once, check the output register
  task automatic cycle(input string tag);
    int g;
    #1;
    g = pick();
    chk({tag, "_in_ready"}, {28'd0, in_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
    @(posedge clk);
    model_edge(g);
    @(negedge clk);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk({tag, "_out_data"}, {24'd0, out_data}, {24'd0, m_data});
      chk({tag, "_out_last"}, {31'd0, out_last}, {31'd0, m_last});
      chk({tag, "_out_src"}, {30'd0, out_src}, m_src);
    end
  endtask

  initial begin
    int rr_exp[6]   = '{0, 1, 2, 3, 0, 1};
    int wrap_exp[4] = '{3, 0, 3, 0};
`ifdef MUX_PKT_LOCK_EN
    int lock_exp[4] = '{1, 1, 1, 0};
`else
    int lock_exp[4] = '{1, 0, 0, 0};
`endif
    logic [7:0] held_data;
    logic [1:0] held_src;

    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    in_data = 32'h44332211; in_valid = 4'b1111; in_last = 4'b1111;
    model_reset();
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", {24'd0, out_data}, 32'd0);
    chk("reset_out_src", {30'd0, out_src}, 32'd0);
    chk("reset_in_ready", {28'd0, in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cycle("rr_all");
      chk("rr_all_seq", {30'd0, out_src}, rr_exp[i]);
    end

    mode = 1'b0; sel = 2'd2; in_data = 32'h33A52211;
    cycle("manual2");
    chk("manual2_data", {24'd0, out_data}, 32'hA5);
    chk("manual2_src", {30'd0, out_src}, 32'd2);
    sel = 2'd1;
    cycle("manual1");
    chk("manual1_data", {24'd0, out_data}, 32'h22);

    mode = 1'b1; in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      cycle("rr_wrap");
      chk("rr_wrap_seq", {30'd0, out_src}, wrap_exp[i]);
    end

    in_valid = 4'b0100;
    cycle("sparse_a");
    cycle("sparse_b");
    chk("sparse_src", {30'd0, out_src}, 32'd2);
    in_valid = 4'b1111;
    cycle("sparse_ptr");
    chk("sparse_ptr_src", {30'd0, out_src}, 32'd3);

    held_data = out_data; held_src = out_src;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("bp");
      chk("bp_ready", {28'd0, in_ready}, 32'd0);
      chk("bp_hold_data", {24'd0, out_data}, {24'd0, held_data});
      chk("bp_hold_src", {30'd0, out_src}, {30'd0, held_src});
    end
    out_ready = 1'b1;
    cycle("bp_release");
    chk("bp_release_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_release_src", {30'd0, out_src}, 32'd0);

    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_out_data", {24'd0, out_data}, 32'd0);
    chk("midreset_in_ready", {28'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mode = 1'b0; sel = 2'd1; in_valid = 4'b0011; in_last = 4'b0001; in_data = 32'h000B0A01;
    cycle("pkt0");
    chk("pkt_seq0", {30'd0, out_src}, lock_exp[0]);
    sel = 2'd0;
    cycle("pkt1");
    chk("pkt_seq1", {30'd0, out_src}, lock_exp[1]);
    in_last = 4'b0011;
    cycle("pkt2");
    chk("pkt_seq2", {30'd0, out_src}, lock_exp[2]);
    in_valid = 4'b0001;
    cycle("pkt3");
    chk("pkt_seq3", {30'd0, out_src}, lock_exp[3]);

    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
